// File: rtl/io_tx_addr_gen.sv
// TX address generator for a uDMA transmit channel: owns the active transfer plus
// one queued configuration, and advances the L2 read address on every granted beat.
module io_tx_addr_gen #(
    parameter int L2_AWIDTH  = 19,
    parameter int TRANS_SIZE = 20
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [L2_AWIDTH-1:0]  cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cfg_continuous_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic                  fifo_req_i,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [L2_AWIDTH-1:0]  addr_o,
    output logic [1:0]            datasize_o,
    output logic                  busy_o,
    output logic                  pending_o,
    output logic [TRANS_SIZE-1:0] bytes_left_o,
    output logic                  eot_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q, state_d;

    logic [L2_AWIDTH-1:0]  addr_q, addr_d;
    logic [TRANS_SIZE-1:0] bytes_left_q, bytes_left_d;
    logic [1:0]            datasize_q, datasize_d;
    logic                  continuous_q, continuous_d;
    logic [L2_AWIDTH-1:0]  start_q, start_d;
    logic [TRANS_SIZE-1:0] size_q, size_d;

    logic                  pend_valid_q, pend_valid_d;
    logic [L2_AWIDTH-1:0]  pend_start_q, pend_start_d;
    logic [TRANS_SIZE-1:0] pend_size_q, pend_size_d;
    logic [1:0]            pend_datasize_q, pend_datasize_d;
    logic                  pend_continuous_q, pend_continuous_d;

    logic                  eot_q, eot_d;

    logic                  cfg_ok;
    logic                  beat;
    logic                  last_beat;
    logic [2:0]            step;

    // A zero-length configuration is treated as if cfg_en_i never happened.
    assign cfg_ok    = cfg_en_i & (cfg_size_i != '0);
    assign req_o     = fifo_req_i & (state_q == RUN);
    assign beat      = req_o & gnt_i;
    assign last_beat = beat & (bytes_left_q <= TRANS_SIZE'(step));

    always_comb begin
        case (datasize_q)
            2'd0:    step = 3'd1;
            2'd1:    step = 3'd2;
            default: step = 3'd4;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        bytes_left_d      = bytes_left_q;
        datasize_d        = datasize_q;
        continuous_d      = continuous_q;
        start_d           = start_q;
        size_d            = size_q;
        pend_valid_d      = pend_valid_q;
        pend_start_d      = pend_start_q;
        pend_size_d       = pend_size_q;
        pend_datasize_d   = pend_datasize_q;
        pend_continuous_d = pend_continuous_q;
        eot_d             = 1'b0;

        if (cfg_clr_i) begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
            bytes_left_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_ok) begin
                        state_d      = RUN;
                        addr_d       = cfg_startaddr_i;
                        bytes_left_d = cfg_size_i;
                        datasize_d   = cfg_datasize_i;
                        continuous_d = cfg_continuous_i;
                        start_d      = cfg_startaddr_i;
                        size_d       = cfg_size_i;
                    end
                end
                RUN: begin
                    if (beat) begin
                        addr_d       = addr_q + L2_AWIDTH'(step);
                        bytes_left_d = bytes_left_q - TRANS_SIZE'(step);
                    end
                    // Reload priority on the last beat: queued, then fresh cfg, then continuous.
                    if (last_beat) begin
                        eot_d = 1'b1;
                        if (pend_valid_q) begin
                            addr_d       = pend_start_q;
                            bytes_left_d = pend_size_q;
                            datasize_d   = pend_datasize_q;
                            continuous_d = pend_continuous_q;
                            start_d      = pend_start_q;
                            size_d       = pend_size_q;
                            pend_valid_d = 1'b0;
                        end else if (cfg_ok) begin
                            addr_d       = cfg_startaddr_i;
                            bytes_left_d = cfg_size_i;
                            datasize_d   = cfg_datasize_i;
                            continuous_d = cfg_continuous_i;
                            start_d      = cfg_startaddr_i;
                            size_d       = cfg_size_i;
                        end else if (continuous_q) begin
                            addr_d       = start_q;
                            bytes_left_d = size_q;
                        end else begin
                            state_d      = IDLE;
                            bytes_left_d = '0;
                        end
                    end else if (cfg_ok && !pend_valid_q) begin
                        pend_valid_d      = 1'b1;
                        pend_start_d      = cfg_startaddr_i;
                        pend_size_d       = cfg_size_i;
                        pend_datasize_d   = cfg_datasize_i;
                        pend_continuous_d = cfg_continuous_i;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            bytes_left_q      <= '0;
            datasize_q        <= '0;
            continuous_q      <= 1'b0;
            start_q           <= '0;
            size_q            <= '0;
            pend_valid_q      <= 1'b0;
            pend_start_q      <= '0;
            pend_size_q       <= '0;
            pend_datasize_q   <= '0;
            pend_continuous_q <= 1'b0;
            eot_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            bytes_left_q      <= bytes_left_d;
            datasize_q        <= datasize_d;
            continuous_q      <= continuous_d;
            start_q           <= start_d;
            size_q            <= size_d;
            pend_valid_q      <= pend_valid_d;
            pend_start_q      <= pend_start_d;
            pend_size_q       <= pend_size_d;
            pend_datasize_q   <= pend_datasize_d;
            pend_continuous_q <= pend_continuous_d;
            eot_q             <= eot_d;
        end
    end

    assign busy_o       = (state_q == RUN);
    assign pending_o    = pend_valid_q;
    assign addr_o       = addr_q;
    assign datasize_o   = datasize_q;
    assign bytes_left_o = bytes_left_q;
    assign eot_o        = eot_q;

endmodule
